fetch_ctrl: RTL and testbench

Instruction-fetch controller sitting directly upstream of the program memory. It owns the architectural program counter, selects the next fetch address (sequential, branch/jump redirect, trap vector), and drives the program memory's address and flush inputs. It also tracks the one-cycle read latency of that memory so the fetched instruction leaves the stage tagged with its own PC and a valid bit for the decode stage.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/next_pc_sel.sv | 53 +++++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_pkg : shared constants and state encoding for fetch_ctrl     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_INC               = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
// +--------------------------------------------------------------------+
// | next_pc_sel : next fetch address priority mux and alignment check  |
// | Optional macro: FETCH_MISALIGN_TRAP_EN.  Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_target,
  input  logic            i_trap_taken,
  input  logic [PC_W-1:0] i_trap_vector,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_redirect,
  output logic            o_misaligned,
  output logic [PC_W-1:0] o_bad_addr
);

  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_aligned;
  logic [PC_W-1:0] w_seq;

  assign w_target   = i_trap_taken ? i_trap_vector : i_redirect_target;
  assign w_seq      = i_pc + PC_W'(PC_INC);
  assign o_redirect = i_trap_taken | i_redirect;
  assign o_bad_addr = w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_misaligned = o_redirect & (w_target[1:0] != 2'b00);
  assign w_aligned    = w_target;
`else
  assign o_misaligned = 1'b0;
  assign w_aligned    = {w_target[PC_W-1:2], 2'b00};
`endif

  // A misaligned target is never loaded; the PC stays put while the trap is raised.
  always_comb begin
    o_next_pc = w_seq;
    if (o_redirect) begin
      o_next_pc = o_misaligned ? i_pc : w_aligned;
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// +--------------------------------------------------------------------+
// | fetch_ctrl : program counter, memory flush and fetch tagging       |
// | Optional macro: FETCH_MISALIGN_TRAP_EN.  Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [PC_W-1:0] RedirectTarget,
  input  logic            TrapTaken,
  input  logic [PC_W-1:0] TrapVector,
  output logic [PC_W-1:0] PC,
  output logic            flush,
  output logic [PC_W-1:0] PC_F,
  output logic            InstrValid,
  output logic            FetchMisaligned,
  output logic [PC_W-1:0] BadAddr
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_f;
  logic            r_instr_valid;
  logic            r_misaligned;
  logic [PC_W-1:0] r_bad_addr;

  logic [PC_W-1:0] w_next_pc;
  logic            w_redirect;
  logic            w_misaligned;
  logic [PC_W-1:0] w_bad_addr;

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .i_pc              (r_pc),
    .i_stall           (Stall),
    .i_redirect        (Redirect),
    .i_redirect_target (RedirectTarget),
    .i_trap_taken      (TrapTaken),
    .i_trap_vector     (TrapVector),
    .o_next_pc         (w_next_pc),
    .o_redirect        (w_redirect),
    .o_misaligned      (w_misaligned),
    .o_bad_addr        (w_bad_addr)
  );

  // Misaligned targets only exist alongside a redirect, so they are covered here.
  assign flush = Reset | w_redirect;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_pc_f        <= RESET_VECTOR;
      r_instr_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_bad_addr    <= '0;
    end else begin
      r_misaligned <= 1'b0;
      if (w_redirect) begin
        // Memory output next cycle is the forced NOP, so mark it invalid.
        r_state       <= FLUSH;
        r_pc          <= w_next_pc;
        r_pc_f        <= r_pc;
        r_instr_valid <= 1'b0;
        if (w_misaligned) begin
          r_misaligned <= 1'b1;
          r_bad_addr   <= w_bad_addr;
        end
      end else begin
        case (r_state)
          BOOT, RUN, FLUSH: begin
            if (!Stall) begin
              r_state       <= RUN;
              r_pc          <= w_next_pc;
              r_pc_f        <= r_pc;
              r_instr_valid <= 1'b1;
            end
          end
          default: r_state <= BOOT;
        endcase
      end
    end
  end

  assign PC              = r_pc;
  assign PC_F            = r_pc_f;
  assign InstrValid      = r_instr_valid;
  assign FetchMisaligned = r_misaligned;
  assign BadAddr         = r_bad_addr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_fetch_ctrl : directed scoreboard bench for fetch_ctrl           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_ctrl;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        TrapTaken;
  logic [31:0] TrapVector;
  logic [31:0] PC;
  logic        flush;
  logic [31:0] PC_F;
  logic        InstrValid;
  logic        FetchMisaligned;
  logic [31:0] BadAddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        chk_pcf;
    logic [31:0] pcf;
    logic        valid;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];

  always #5 Clock = ~Clock;

  fetch_ctrl #(
    .PC_W         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .TrapTaken       (TrapTaken),
    .TrapVector      (TrapVector),
    .PC              (PC),
    .flush           (flush),
    .PC_F            (PC_F),
    .InstrValid      (InstrValid),
    .FetchMisaligned (FetchMisaligned),
    .BadAddr         (BadAddr)
  );

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check flush combinationally, then check registered state after the edge.
  task automatic step(input string tag, input logic rst, input logic stall, input logic rd,
                      input logic [31:0] tgt, input logic tr, input logic [31:0] vec,
                      input logic exp_flush, input logic [31:0] exp_pc, input logic chk_pcf,
                      input logic [31:0] exp_pcf, input logic exp_valid, input logic exp_mis,
                      input logic [31:0] exp_bad);
    exp_t e;
    Reset          = rst;
    Stall          = stall;
    Redirect       = rd;
    RedirectTarget = tgt;
    TrapTaken      = tr;
    TrapVector     = vec;
    #1;
    chk(tag, "flush", {31'd0, flush}, {31'd0, exp_flush});
    sb.push_back('{tag, exp_pc, chk_pcf, exp_pcf, exp_valid, exp_mis, exp_bad});
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    chk(e.tag, "PC", PC, e.pc);
    if (e.chk_pcf) chk(e.tag, "PC_F", PC_F, e.pcf);
    chk(e.tag, "InstrValid", {31'd0, InstrValid}, {31'd0, e.valid});
    chk(e.tag, "FetchMisaligned", {31'd0, FetchMisaligned}, {31'd0, e.mis});
    chk(e.tag, "BadAddr", BadAddr, e.bad);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad_m;
    bad_m          = MIS ? 32'h42 : 32'h0;
    Reset          = 1'b1;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = '0;
    TrapTaken      = 1'b0;
    TrapVector     = '0;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 3; i++)
      step("reset", 1, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 0, 0, 32'h0);

    step("boot",  0, 0, 0, 0, 0, 0, 0, 32'h04, 1, 32'h00, 1, 0, 32'h0);
    step("seq1",  0, 0, 0, 0, 0, 0, 0, 32'h08, 1, 32'h04, 1, 0, 32'h0);
    step("seq2",  0, 0, 0, 0, 0, 0, 0, 32'h0C, 1, 32'h08, 1, 0, 32'h0);
    step("seq3",  0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 32'h0C, 1, 0, 32'h0);

    step("redir40", 0, 0, 1, 32'h40, 0, 0, 1, 32'h40, 0, 32'h0,  0, 0, 32'h0);
    step("flush40", 0, 0, 0, 0,      0, 0, 0, 32'h44, 1, 32'h40, 1, 0, 32'h0);
    step("seq44",   0, 0, 0, 0,      0, 0, 0, 32'h48, 1, 32'h44, 1, 0, 32'h0);

    step("redir1c", 0, 0, 1, 32'h1C, 0, 0, 1, 32'h1C, 0, 32'h0,  0, 0, 32'h0);
    step("flush1c", 0, 0, 0, 0,      0, 0, 0, 32'h20, 1, 32'h1C, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      step("stall", 0, 1, 0, 0, 0, 0, 0, 32'h20, 1, 32'h1C, 1, 0, 32'h0);
    step("resume",  0, 0, 0, 0,      0, 0, 0, 32'h24, 1, 32'h20, 1, 0, 32'h0);

    step("trap_pri", 0, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0);
    step("flush100", 0, 0, 0, 0,      0, 0,       0, 32'h104, 1, 32'h100, 1, 0, 32'h0);

    step("b2b_a", 0, 0, 1, 32'h40, 0, 0, 1, 32'h40, 0, 32'h0,  0, 0, 32'h0);
    step("b2b_b", 0, 0, 1, 32'h80, 0, 0, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0);
    step("b2b_c", 0, 0, 0, 0,      0, 0, 0, 32'h84, 1, 32'h80, 1, 0, 32'h0);

    step("redir_stall", 0, 1, 1, 32'h200, 0, 0, 1, 32'h200, 0, 32'h0,   0, 0, 32'h0);
    step("flush200",    0, 0, 0, 0,       0, 0, 0, 32'h204, 1, 32'h200, 1, 0, 32'h0);

    step("mis", 0, 0, 1, 32'h42, 0, 0, 1,
         MIS ? 32'h204 : 32'h40, 0, 32'h0, 0, MIS, bad_m);
    step("mis_after", 0, 0, 0, 0, 0, 0, 0,
         MIS ? 32'h208 : 32'h44, 1, MIS ? 32'h204 : 32'h40, 1, 0, bad_m);

    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 0, bad_m);
    step("wrap",       0, 0, 0, 0,             0, 0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1, 0, bad_m);

    step("rst_mid", 1, 0, 1, 32'h300, 0, 0, 1, 32'h0, 1, 32'h0, 0, 0, 32'h0);
    step("rst_rel", 0, 0, 0, 0,       0, 0, 0, 32'h4, 1, 32'h0, 1, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
